// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave that resynchronises SCLK/MOSI/LOAD into clk, shifts in one M-bit
// word per LOAD-low frame and returns a preloaded word on MISO.
// Optional feature macro SPI_SLAVE_HOLD_EN: rx_vld holds until rx_ack instead of pulsing.
module spi_slave_rx #(
    parameter int M           = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         SCLK,
    input  logic         MOSI,
    input  logic         LOAD,
    output logic         MISO,
    input  logic [M-1:0] TX_DI,
    input  logic         tx_we,
    input  logic         rx_ack,
    output logic [M-1:0] RX_DO,
    output logic         rx_vld,
    output logic         frm_err,
    output logic         busy,
    output logic [7:0]   cb_bit
);
    logic [SYNC_STAGES-1:0] r_sclk_s, r_mosi_s, r_load_s;
    logic                   r_sclk_d, r_load_d;
    logic [SYNC_STAGES:0]   r_warm;
    logic                   r_armed;
    logic [M-1:0]           r_tx_buf, r_sr_tx, r_sr_rx, r_rx_do;
    logic [7:0]             r_cb;
    logic                   r_miso, r_vld, r_err, r_busy;
    logic                   w_sclk, w_mosi, w_load;
    logic                   w_sclk_rise, w_sclk_fall, w_load_rise, w_load_fall;
    logic                   w_start, w_done_ok, w_take;
    logic [M-1:0]           w_tx_load;

    assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
    assign w_load      = r_load_s[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_load_rise = w_load & ~r_load_d;
    assign w_load_fall = ~w_load & r_load_d;
    // a fall only starts a frame once LOAD has been genuinely seen high after reset
    assign w_start     = w_load_fall & r_armed;
    assign w_tx_load   = tx_we ? TX_DI : r_tx_buf;
    assign w_done_ok   = (r_cb == 8'(M));
`ifdef SPI_SLAVE_HOLD_EN
    assign w_take      = ~r_vld | rx_ack;
`else
    logic w_unused;
    assign w_take      = 1'b1;
    assign w_unused    = rx_ack;
`endif

    assign MISO    = r_miso;
    assign RX_DO   = r_rx_do;
    assign rx_vld  = r_vld;
    assign frm_err = r_err;
    assign busy    = r_busy;
    assign cb_bit  = r_cb;

    // Resynchronise pins, keep previous levels for edge detection, arm after the pipeline flushes
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_sclk_s <= '0;
            r_mosi_s <= '0;
            r_load_s <= '1;
            r_sclk_d <= 1'b0;
            r_load_d <= 1'b1;
            r_warm   <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], SCLK};
            r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], MOSI};
            r_load_s <= {r_load_s[SYNC_STAGES-2:0], LOAD};
            r_sclk_d <= w_sclk;
            r_load_d <= w_load;
            r_warm   <= {r_warm[SYNC_STAGES-1:0], 1'b1};
            r_armed  <= r_armed | (r_warm[SYNC_STAGES] & w_load);
        end
    end

    // Frame sequencing, shift registers and result reporting
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_tx_buf <= '0;
            r_sr_tx  <= '0;
            r_sr_rx  <= '0;
            r_rx_do  <= '0;
            r_cb     <= '0;
            r_miso   <= 1'b0;
            r_vld    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_err <= 1'b0;
`ifdef SPI_SLAVE_HOLD_EN
            r_vld <= r_vld & ~rx_ack;
`else
            r_vld <= 1'b0;
`endif
            if (tx_we)
                r_tx_buf <= TX_DI;
            if (w_start) begin
                r_busy  <= 1'b1;
                r_cb    <= '0;
                r_sr_rx <= '0;
                r_sr_tx <= w_tx_load;
                r_miso  <= w_tx_load[M-1];
            end else if (r_busy && w_load_rise) begin
                r_busy <= 1'b0;
                if (w_done_ok && w_take) begin
                    r_rx_do <= r_sr_rx;
                    r_vld   <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (r_busy) begin
                if (w_sclk_rise) begin
                    r_sr_rx <= {r_sr_rx[M-2:0], w_mosi};
                    r_cb    <= (r_cb == 8'hFF) ? r_cb : r_cb + 8'd1;
                end
                if (w_sclk_fall) begin
                    r_sr_tx <= {r_sr_tx[M-2:0], 1'b0};
                    r_miso  <= r_sr_tx[M-2];
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: randomized scoreboard bench for spi_slave_rx with a frame-level reference model
module tb_spi_slave_rx;
    localparam int S = 2;
`ifdef SPI_SLAVE_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } exp_t;

    logic        clk = 0, clr = 0, SCLK = 0, MOSI = 0, LOAD = 1, tx_we = 0, rx_ack = 0;
    logic [15:0] TX_DI = '0;
    logic        MISO, rx_vld, frm_err, busy;
    logic [15:0] RX_DO;
    logic [7:0]  cb_bit;

    int          total = 0, bad = 0;
    exp_t        q[$];
    logic [15:0] tx_buf_m = '0, rx_do_m = '0;
    bit          vld_m = 0, auto_ack = 1;
    logic        vld_q = 0;

    spi_slave_rx #(.M(16), .SYNC_STAGES(S)) dut (
        .clk(clk), .clr(clr), .SCLK(SCLK), .MOSI(MOSI), .LOAD(LOAD), .MISO(MISO),
        .TX_DI(TX_DI), .tx_we(tx_we), .rx_ack(rx_ack), .RX_DO(RX_DO), .rx_vld(rx_vld),
        .frm_err(frm_err), .busy(busy), .cb_bit(cb_bit)
    );

    always #5 clk = ~clk;

    function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation whenever the DUT reports a frame result
    always @(negedge clk) begin
        exp_t e;
        logic evt;
        evt = frm_err | (HOLD ? (rx_vld & ~vld_q) : rx_vld);
        if (evt) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got vld=%0b err=%0b want none", rx_vld, frm_err);
            end else begin
                e = q.pop_front();
                cmp("evt_err", frm_err, e.err);
                cmp("rx_do", RX_DO, e.data);
            end
        end
        vld_q <= rx_vld;
    end

    // One master frame: nb SCLK pulses with half-period hp; optional mid-frame reset or tx_we
    task automatic frame(input logic [15:0] d, input int nb, input int hp, input bit exp_evt,
                         input int rst_at, input int we_at, input logic [15:0] we_val,
                         input bit chk_miso);
        logic [15:0] exp_tx, got, mask;
        bit          did_rst, v0;
        int          c;
        exp_tx  = tx_buf_m;
        got     = '0;
        did_rst = 0;
        LOAD    = 0;
        wait_clk(hp);
        cmp("busy_in_frame", busy, 1);
        for (int i = 0; i < nb; i++) begin
            if (i == rst_at) begin
                clr = 0;
                wait_clk(1);
                clr = 1;
                rx_do_m  = '0;
                tx_buf_m = '0;
                vld_m    = 0;
                did_rst  = 1;
            end
            if (i == we_at) begin
                TX_DI = we_val;
                tx_we = 1;
                wait_clk(1);
                tx_we = 0;
                tx_buf_m = we_val;
            end
            MOSI = (i < 16) ? d[15-i] : 1'b0;
            wait_clk(hp);
            SCLK = 1;
            if (i < 16)
                got[15-i] = MISO;
            wait_clk(hp);
            SCLK = 0;
        end
        wait_clk(hp);
        if (exp_evt) begin
            if (nb == 16 && !(HOLD && vld_m)) begin
                rx_do_m = d;
                vld_m   = 1;
                q.push_back({1'b0, d});
            end else begin
                q.push_back({1'b1, rx_do_m});
            end
        end
        v0   = rx_vld;
        LOAD = 1;
        for (c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (frm_err || (rx_vld && !v0))
                break;
        end
        if (exp_evt)
            cmp("latency", c, S + 1);
        else
            cmp("no_event", c, 41);
        if (HOLD && auto_ack && exp_evt) begin
            rx_ack = 1;
            wait_clk(1);
            rx_ack = 0;
            vld_m  = 0;
        end
        wait_clk(2);
        cmp("busy_after", busy, 0);
        cmp("cb_bit", cb_bit, did_rst ? 0 : (nb > 255 ? 255 : nb));
        if (chk_miso) begin
            mask = (nb >= 16) ? 16'hFFFF : ~(16'hFFFF >> nb);
            cmp("miso_word", got & mask, exp_tx & mask);
        end
        wait_clk(hp);
    endtask

    initial begin
        logic [15:0] d;
        int          nb, we_at;
        wait_clk(3);
        clr = 1;
        for (int i = 0; i < 6; i++) begin
            SCLK = ~SCLK;
            wait_clk(4);
            cmp("idle_rx_do", RX_DO, 0);
            cmp("idle_vld", rx_vld, 0);
            cmp("idle_miso", MISO, 0);
            cmp("idle_cb", cb_bit, 0);
            cmp("idle_busy", busy, 0);
        end
        SCLK = 0;
        wait_clk(8);
        TX_DI = 16'hA5C3;
        tx_we = 1;
        wait_clk(1);
        tx_we = 0;
        tx_buf_m = 16'hA5C3;
        frame(16'h1234, 16, 500, 1, -1, -1, '0, 1);
        cmp("rx_do_1234", RX_DO, 16'h1234);
        frame(16'h5A5A, 15, 8, 1, -1, -1, '0, 1);
        cmp("rx_do_kept", RX_DO, 16'h1234);
        frame(16'hC0DE, 16, 6, 1, -1, 5, 16'h00FF, 1);
        frame(16'h0F0F, 16, 6, 1, -1, -1, '0, 1);
        frame(16'h7777, 16, 6, 0, 8, -1, '0, 0);
        frame(16'hBEEF, 16, 6, 1, -1, -1, '0, 1);
        cmp("rx_do_beef", RX_DO, 16'hBEEF);
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                TX_DI = 16'($urandom);
                tx_we = 1;
                wait_clk(1);
                tx_we = 0;
                tx_buf_m = TX_DI;
            end
            d     = 16'($urandom);
            nb    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : 16;
            we_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
            frame(d, nb, $urandom_range(4, 10), 1, -1, we_at, 16'($urandom), 1);
        end
`ifdef SPI_SLAVE_HOLD_EN
        auto_ack = 0;
        frame(16'h1111, 16, 6, 1, -1, -1, '0, 1);
        frame(16'h2222, 16, 6, 1, -1, -1, '0, 1);
        cmp("hold_vld", rx_vld, 1);
        cmp("hold_rx_do", RX_DO, 16'h1111);
        rx_ack = 1;
        wait_clk(1);
        rx_ack = 0;
        cmp("ack_clears", rx_vld, 0);
`endif
        wait_clk(5);
        cmp("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
